// File: rtl/uvme_cvmcu_chip_io_evt_pkg.sv
// Shared defaults, the event record layout and the saturating drop-count helper.
package uvme_cvmcu_chip_io_evt_pkg;

    localparam int NUM_IO_DEF = 48;
    localparam int TS_W_DEF   = 32;
    localparam int DROP_W     = 16;

    typedef struct packed {
        logic [NUM_IO_DEF-1:0] out;
        logic [NUM_IO_DEF-1:0] oe;
        logic [TS_W_DEF-1:0]   ts;
        logic                  ovf;
    } evt_t;

    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
        return (v == {DROP_W{1'b1}}) ? v : v + DROP_W'(1);
    endfunction

endpackage

// File: rtl/uvme_cvmcu_chip_io_evt_fifo.sv
// Event FIFO: valid/ready on both sides, synchronous flush, occupancy level.
// Latency 1 from push to out_vld_o; in_rdy_o stays high when full if a pop happens in the same cycle.
// Backpressure: entries are held while out_rdy_i is low; flush wins over push/pop.
module uvme_cvmcu_chip_io_evt_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH),
    localparam int LW   = AW + 1
) (
    input  logic          core_clk,
    input  logic          arst_n,
    input  logic          flush_i,
    input  logic          in_vld_i,
    output logic          in_rdy_o,
    input  logic [W-1:0]  in_dat_i,
    output logic          out_vld_o,
    input  logic          out_rdy_i,
    output logic [W-1:0]  out_dat_o,
    output logic [LW-1:0] level_o
);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic [W-1:0]  mem_q [DEPTH];
    logic          push, pop, full;

    assign full      = (level_q == LW'(DEPTH));
    assign out_vld_o = (level_q != '0);
    assign pop       = out_vld_o && out_rdy_i;
    assign in_rdy_o  = !full || out_rdy_i;
    assign push      = in_vld_i && in_rdy_o;
    assign out_dat_o = out_vld_o ? mem_q[rd_ptr_q] : '0;
    assign level_o   = level_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: out_dat_o is masked whenever the FIFO is empty.
    always_ff @(posedge core_clk) begin
        if (push && !flush_i) mem_q[wr_ptr_q] <= in_dat_i;
    end

endmodule

// File: rtl/uvme_cvmcu_chip_io_evt_capture.sv
// Timestamps changes of the chip's driven IO pattern and queues them as events.
// Latency 1 from the change cycle to evt_valid_o when the queue is empty.
// Backpressure: events wait in the FIFO; a change arriving while full without a pop is dropped and counted.
module uvme_cvmcu_chip_io_evt_capture
    import uvme_cvmcu_chip_io_evt_pkg::*;
#(
    parameter int NUM_IO = NUM_IO_DEF,
    parameter int DEPTH  = 8,
    parameter int TS_W   = TS_W_DEF
) (
    input  logic                     ref_clk_i,
    input  logic                     rstn_i,
    input  logic                     en_i,
    input  logic                     clr_i,
    input  logic [NUM_IO-1:0]        io_out_i,
    input  logic [NUM_IO-1:0]        io_oe_i,
    output logic                     evt_valid_o,
    input  logic                     evt_ready_i,
    output logic [NUM_IO-1:0]        evt_out_o,
    output logic [NUM_IO-1:0]        evt_oe_o,
    output logic [TS_W-1:0]          evt_ts_o,
    output logic                     evt_ovf_o,
    output logic [DROP_W-1:0]        drop_cnt_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    typedef struct packed {
        logic [NUM_IO-1:0] out;
        logic [NUM_IO-1:0] oe;
        logic [TS_W-1:0]   ts;
        logic              ovf;
    } rec_t;

    logic [TS_W-1:0]     ts_q, ts_d;
    logic [2*NUM_IO-1:0] p_q, p_d;
    logic [2*NUM_IO-1:0] samp;
    logic                en_q, en_d;
    logic                pend_q, pend_d;
    logic [DROP_W-1:0]   drop_q, drop_d;
    logic                push_vld, push_rdy;
    rec_t                push_rec, pop_rec;

    assign samp = {io_out_i & io_oe_i, io_oe_i};

    always_comb begin
        ts_d     = clr_i ? '0 : ts_q + TS_W'(1);
        en_d     = en_i;
        p_d      = p_q;
        pend_d   = pend_q;
        drop_d   = drop_q;
        push_vld = 1'b0;
        if (clr_i) begin
            p_d    = samp;
            pend_d = 1'b0;
            drop_d = '0;
        end else if (en_i) begin
            // The first enabled cycle only captures a baseline; changes count from the next one.
            p_d      = samp;
            push_vld = en_q && (samp != p_q);
            if (push_vld && push_rdy) begin
                pend_d = 1'b0;
            end else if (push_vld) begin
                pend_d = 1'b1;
                drop_d = sat_inc(drop_q);
            end
        end
    end

    always_ff @(posedge ref_clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            ts_q   <= '0;
            p_q    <= '0;
            en_q   <= 1'b0;
            pend_q <= 1'b0;
            drop_q <= '0;
        end else begin
            ts_q   <= ts_d;
            p_q    <= p_d;
            en_q   <= en_d;
            pend_q <= pend_d;
            drop_q <= drop_d;
        end
    end

    always_comb begin
        push_rec.out = samp[2*NUM_IO-1:NUM_IO];
        push_rec.oe  = samp[NUM_IO-1:0];
        push_rec.ts  = ts_q;
        push_rec.ovf = pend_q;
    end

    uvme_cvmcu_chip_io_evt_fifo #(
        .W     ($bits(rec_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .core_clk  (ref_clk_i),
        .arst_n    (rstn_i),
        .flush_i   (clr_i),
        .in_vld_i  (push_vld),
        .in_rdy_o  (push_rdy),
        .in_dat_i  (push_rec),
        .out_vld_o (evt_valid_o),
        .out_rdy_i (evt_ready_i),
        .out_dat_o (pop_rec),
        .level_o   (level_o)
    );

    assign evt_out_o  = pop_rec.out;
    assign evt_oe_o   = pop_rec.oe;
    assign evt_ts_o   = pop_rec.ts;
    assign evt_ovf_o  = pop_rec.ovf;
    assign drop_cnt_o = drop_q;

endmodule

// File: tb/tb_uvme_cvmcu_chip_io_evt_capture.sv
// Directed scoreboard bench: stimulus pushes expected events, negedge monitors pop and compare.
module tb_uvme_cvmcu_chip_io_evt_capture;
    import uvme_cvmcu_chip_io_evt_pkg::*;

    localparam int N = 48;
    localparam logic [N-1:0] ALL = {N{1'b1}};

    logic          ref_clk_i = 1'b0;
    logic          rstn_i, en_i, clr_i, evt_ready_i, evt_valid_o, evt_ovf_o;
    logic [N-1:0]  io_out_i, io_oe_i, evt_out_o, evt_oe_o;
    logic [31:0]   evt_ts_o;
    logic [15:0]   drop_cnt_o;
    logic [3:0]    level_o;

    logic          en8, clr8, rdy8, vld8, ovf8;
    logic [N-1:0]  out8, oe8, eo8, eoe8;
    logic [7:0]    ts8;
    logic [15:0]   drop8;
    logic [3:0]    lvl8;

    typedef struct packed {
        logic [N-1:0] out;
        logic [N-1:0] oe;
        logic [7:0]   ts;
        logic         ovf;
    } ev8_t;

    evt_t exp_q[$];
    ev8_t exp8_q[$];
    int   checks = 0;
    int   errors = 0;
    int   ts_now = 0;
    bit   d8_done = 1'b0;

    always #5 ref_clk_i = ~ref_clk_i;

    uvme_cvmcu_chip_io_evt_capture #(.NUM_IO(N), .DEPTH(8), .TS_W(32)) dut (
        .ref_clk_i(ref_clk_i), .rstn_i(rstn_i), .en_i(en_i), .clr_i(clr_i),
        .io_out_i(io_out_i), .io_oe_i(io_oe_i), .evt_valid_o(evt_valid_o),
        .evt_ready_i(evt_ready_i), .evt_out_o(evt_out_o), .evt_oe_o(evt_oe_o),
        .evt_ts_o(evt_ts_o), .evt_ovf_o(evt_ovf_o), .drop_cnt_o(drop_cnt_o),
        .level_o(level_o)
    );

    uvme_cvmcu_chip_io_evt_capture #(.NUM_IO(N), .DEPTH(8), .TS_W(8)) dut8 (
        .ref_clk_i(ref_clk_i), .rstn_i(rstn_i), .en_i(en8), .clr_i(clr8),
        .io_out_i(out8), .io_oe_i(oe8), .evt_valid_o(vld8),
        .evt_ready_i(rdy8), .evt_out_o(eo8), .evt_oe_o(eoe8),
        .evt_ts_o(ts8), .evt_ovf_o(ovf8), .drop_cnt_o(drop8),
        .level_o(lvl8)
    );

    task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        bit c;
        c = clr_i;
        @(posedge ref_clk_i);
        #1;
        ts_now = c ? 0 : ts_now + 1;
    endtask

    task automatic exp_lit(input logic [N-1:0] o, input logic [N-1:0] e,
                           input logic [31:0] t, input logic v);
        evt_t x;
        x.out = o;
        x.oe  = e;
        x.ts  = t;
        x.ovf = v;
        exp_q.push_back(x);
    endtask

    task automatic exp_evt(input logic v);
        exp_lit(io_out_i & io_oe_i, io_oe_i, ts_now[31:0], v);
    endtask

    // Main monitor: compares on every accepted event and checks hold stability under backpressure.
    evt_t got, held;
    bit   held_v = 1'b0;
    always @(negedge ref_clk_i) begin
        if (!rstn_i) begin
            held_v = 1'b0;
        end else if (evt_valid_o) begin
            got.out = evt_out_o;
            got.oe  = evt_oe_o;
            got.ts  = evt_ts_o;
            got.ovf = evt_ovf_o;
            if (held_v) chk("stable_hold", got, held);
            held_v = 1'b0;
            if (evt_ready_i) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_evt actual=%0h required=none", got);
                end else begin
                    chk("evt", got, exp_q.pop_front());
                end
            end else begin
                held   = got;
                held_v = 1'b1;
            end
        end else begin
            held_v = 1'b0;
        end
    end

    ev8_t got8;
    always @(negedge ref_clk_i) begin
        if (rstn_i && vld8 && rdy8) begin
            got8.out = eo8;
            got8.oe  = eoe8;
            got8.ts  = ts8;
            got8.ovf = ovf8;
            if (exp8_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_evt8 actual=%0h required=none", got8);
            end else begin
                chk("evt8", got8, exp8_q.pop_front());
            end
        end
    end

    // Narrow-timestamp instance: changes straddling the 255 -> 0 wrap.
    initial begin
        ev8_t x;
        @(posedge rstn_i);
        repeat (255) begin @(posedge ref_clk_i); #1; end
        out8 = 48'h1;
        x.out = 48'h1; x.oe = ALL; x.ts = 8'd255; x.ovf = 1'b0;
        exp8_q.push_back(x);
        @(posedge ref_clk_i); #1;
        out8 = 48'h0;
        x.out = 48'h0; x.oe = ALL; x.ts = 8'd0; x.ovf = 1'b0;
        exp8_q.push_back(x);
        repeat (4) begin @(posedge ref_clk_i); #1; end
        d8_done = 1'b1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1);
    end

    initial begin
        rstn_i = 1'b0; en_i = 1'b0; clr_i = 1'b0; evt_ready_i = 1'b1;
        io_out_i = '0; io_oe_i = '0;
        en8 = 1'b1; clr8 = 1'b0; rdy8 = 1'b1; out8 = '0; oe8 = ALL;
        repeat (3) @(posedge ref_clk_i);
        #1;
        chk("rst_valid", evt_valid_o, 0);
        chk("rst_level", level_o, 0);
        chk("rst_drop", drop_cnt_o, 0);
        chk("rst_outputs", {evt_out_o, evt_oe_o, evt_ts_o, evt_ovf_o}, 0);
        en_i = 1'b1;
        io_oe_i = ALL;
        @(posedge ref_clk_i); #1;
        rstn_i = 1'b1;
        ts_now = 0;

        // Bit0 toggle at timestamp 10, first cycle is baseline only.
        repeat (10) tick();
        io_out_i = 48'h1;
        exp_lit(48'h1, ALL, 32'd10, 1'b0);
        tick();
        chk("latency1_valid", evt_valid_o, 1);
        repeat (2) tick();

        // Undriven bit changes are masked; enabling its oe reveals it.
        io_oe_i = 48'hFFFF_FFFF_FFDF;
        exp_lit(48'h1, 48'hFFFF_FFFF_FFDF, ts_now[31:0], 1'b0);
        tick();
        io_out_i = 48'h21;
        repeat (3) tick();
        chk("masked_level", level_o, 0);
        chk("masked_valid", evt_valid_o, 0);
        io_oe_i = ALL;
        exp_lit(48'h21, ALL, ts_now[31:0], 1'b0);
        tick();
        repeat (3) tick();

        // Overflow: 10 changes into 8 entries.
        evt_ready_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            io_out_i ^= 48'h2;
            if (i < 8) exp_evt(1'b0);
            tick();
        end
        chk("full_level", level_o, 8);
        chk("drop_two", drop_cnt_o, 2);
        evt_ready_i = 1'b1;
        repeat (10) tick();
        chk("drained_level", level_o, 0);
        chk("drained_all", exp_q.size(), 0);
        io_out_i ^= 48'h2;
        exp_evt(1'b1);
        repeat (3) tick();
        chk("drop_hold", drop_cnt_o, 2);

        // Full with simultaneous pop and push.
        evt_ready_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            io_out_i ^= 48'h4;
            exp_evt(1'b0);
            tick();
        end
        chk("refill_level", level_o, 8);
        evt_ready_i = 1'b1;
        io_out_i ^= 48'h4;
        exp_evt(1'b0);
        tick();
        chk("pushpop_full_level", level_o, 8);
        chk("pushpop_no_drop", drop_cnt_o, 2);
        repeat (10) tick();

        // Clear with queued events and drops outstanding.
        clr_i = 1'b1;
        tick();
        clr_i = 1'b0;
        chk("clr_drop_zero", drop_cnt_o, 0);
        evt_ready_i = 1'b0;
        for (int i = 0; i < 12; i++) begin
            io_out_i ^= 48'h8;
            if (i < 8) exp_evt(1'b0);
            tick();
        end
        chk("pre_clr_drop", drop_cnt_o, 4);
        evt_ready_i = 1'b1;
        repeat (5) tick();
        evt_ready_i = 1'b0;
        chk("pre_clr_level", level_o, 3);
        clr_i = 1'b1;
        tick();
        clr_i = 1'b0;
        exp_q.delete();
        chk("clr_level", level_o, 0);
        chk("clr_valid", evt_valid_o, 0);
        chk("clr_drop", drop_cnt_o, 0);
        evt_ready_i = 1'b1;
        repeat (4) tick();
        chk("clr_no_evt", level_o, 0);
        io_out_i ^= 48'h8;
        exp_evt(1'b0);
        repeat (4) tick();

        // Disabled capture blocks pushes but keeps draining; re-enable is a baseline.
        evt_ready_i = 1'b0;
        io_out_i ^= 48'h10;
        exp_evt(1'b0);
        tick();
        en_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            io_out_i ^= 48'h10;
            tick();
        end
        chk("disabled_level", level_o, 1);
        evt_ready_i = 1'b1;
        repeat (3) tick();
        chk("disabled_drain", level_o, 0);
        en_i = 1'b1;
        repeat (4) tick();
        chk("reenable_baseline", level_o, 0);

        for (int i = 0; i < 1000 && !d8_done; i++) tick();
        chk("ts8_done", d8_done, 1);

        // Reset in the middle of queued traffic.
        evt_ready_i = 1'b0;
        io_out_i ^= 48'h2;
        exp_evt(1'b0);
        tick();
        io_out_i ^= 48'h2;
        exp_evt(1'b0);
        tick();
        chk("pre_rst_level", level_o, 2);
        #2;
        rstn_i = 1'b0;
        #1;
        chk("midrst_valid", evt_valid_o, 0);
        chk("midrst_level", level_o, 0);
        exp_q.delete();
        io_out_i ^= 48'h40;
        @(posedge ref_clk_i); #1;
        rstn_i = 1'b1;
        ts_now = 0;
        evt_ready_i = 1'b1;
        repeat (4) tick();
        chk("post_rst_baseline", level_o, 0);
        io_out_i ^= 48'h2;
        exp_evt(1'b0);
        repeat (4) tick();

        chk("all_evts_seen", exp_q.size(), 0);
        chk("all_evt8_seen", exp8_q.size(), 0);
        chk("ts8_drop", drop8, 0);
        chk("ts8_level", lvl8, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
